// File: rtl/count_sampler_pkg.sv
// count_sampler_pkg: shared widths, sample payload layout, readout state
// encoding and the byte-select helper used by the count sampler.
package count_sampler_pkg;

    localparam int unsigned COUNT_W          = 24;
    localparam int unsigned SAMPLE_W         = 48;
    localparam int unsigned BYTES_PER_SAMPLE = 6;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned LEVEL_W          = 5;
    localparam int unsigned SEQ_W            = 8;

    // Readout state: IDLE sits at byte index 0, READING covers 1..5.
    typedef enum logic {
        RD_IDLE    = 1'b0,
        RD_READING = 1'b1
    } rd_state_e;

    // One buffered sample; p occupies the upper half [47:24].
    typedef struct packed {
        logic [COUNT_W-1:0] p;
        logic [COUNT_W-1:0] m;
    } sample_t;

    // Byte idx of a sample in readout order, MSB of count_p first.
    function automatic logic [BYTE_W-1:0] sample_byte(input sample_t s,
                                                      input logic [IDX_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        b = '0;
        case (idx)
            3'd0:    b = s.p[23:16];
            3'd1:    b = s.p[15:8];
            3'd2:    b = s.p[7:0];
            3'd3:    b = s.m[23:16];
            3'd4:    b = s.m[15:8];
            3'd5:    b = s.m[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gate_edge_sync.sv
// gate_edge_sync: brings the asynchronous gate into the clk_12mhz domain and
// flags its rising edge.
//   clk_12mhz   - sampling clock
//   reset       - asynchronous active-high reset (clears the chain to 0)
//   gate        - asynchronous gate input
//   gate_rise_c - one-cycle pulse on a rising edge of the synchronized gate
module gate_edge_sync #(
    parameter int unsigned GATE_SYNC = 2
) (
    input  logic clk_12mhz,
    input  logic reset,
    input  logic gate,
    output logic gate_rise_c
);

    logic [GATE_SYNC-1:0] sync_q;
    logic                 prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[GATE_SYNC-2:0], gate};
            prev_q <= sync_q[GATE_SYNC-1];
        end
    end

    // Chain resets low, so a gate already high at reset release yields one rise.
    assign gate_rise_c = sync_q[GATE_SYNC-1] & ~prev_q;

endmodule

// File: rtl/count_sampler.sv
// count_sampler: captures {count_p, count_m} on each gate rising edge into a
// DEPTH-entry buffer and serves the head sample as six bytes, MSB first.
//   clk_12mhz, reset  - clock and asynchronous active-high reset
//   gate              - asynchronous measurement gate
//   count_p, count_m  - counter values latched on the gate edge
//   rd_en, flush      - byte readout request, buffer/status clear
//   rd_data, rd_valid - readout byte and its one-cycle strobe
//   empty, full, level, overflow, seq - buffer status
module count_sampler
    import count_sampler_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned GATE_SYNC = 2
) (
    input  logic               clk_12mhz,
    input  logic               reset,
    input  logic               gate,
    input  logic [COUNT_W-1:0] count_p,
    input  logic [COUNT_W-1:0] count_m,
    input  logic               rd_en,
    input  logic               flush,
    output logic [BYTE_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic [SEQ_W-1:0]   seq
);

    localparam int unsigned        PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);

    logic               gate_rise_c;
    sample_t            sample_q;
    logic               wr_pend_q;
    sample_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    rd_state_e          state_q, state_d;
    logic               overflow_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [BYTE_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic               rd_take_c, pop_c, wr_ok_c, drop_c;

    gate_edge_sync #(.GATE_SYNC(GATE_SYNC)) u_gate_edge_sync (
        .clk_12mhz   (clk_12mhz),
        .reset       (reset),
        .gate        (gate),
        .gate_rise_c (gate_rise_c)
    );

    // Status is combinational from the registered level.
    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign seq      = seq_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Readout FSM next state, pop/write decisions and next level.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_take_c = 1'b0;
        pop_c     = 1'b0;
        wr_ok_c   = 1'b0;
        drop_c    = 1'b0;
        level_d   = level_q;
        if (flush) begin
            state_d = RD_IDLE;
            idx_d   = '0;
            level_d = '0;
        end else begin
            if (rd_en && !empty) begin
                rd_take_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    pop_c   = 1'b1;
                    idx_d   = '0;
                    state_d = RD_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RD_READING;
                end
            end
            // A final-byte pop frees the slot even when the buffer is full.
            if (wr_pend_q) begin
                if ((level_q != DEPTH_L) || pop_c) begin
                    wr_ok_c = 1'b1;
                end else begin
                    drop_c = 1'b1;
                end
            end
            case ({wr_ok_c, pop_c})
                2'b10:   level_d = level_q + LEVEL_W'(1);
                2'b01:   level_d = level_q - LEVEL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Readout state register.
    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture, pointers, status and readout byte.
    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            sample_q   <= '0;
            wr_pend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            seq_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (gate_rise_c) begin
                sample_q <= '{p: count_p, m: count_m};
            end
            wr_pend_q <= gate_rise_c;
            level_q   <= level_d;
            if (flush) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_q <= 1'b0;
                seq_q      <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_take_c;
                if (rd_take_c) begin
                    rd_data_q <= sample_byte(mem_q[rd_ptr_q], idx_q);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (wr_ok_c) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    seq_q    <= seq_q + SEQ_W'(1);
                end
                if (drop_c) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk_12mhz) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q] <= sample_q;
        end
    end

endmodule
